// File: rtl/pipelined_mux_n.sv
// Registered N-way word multiplexer with valid/ready flow control.
// One output register plus one skid register; sticky bad-select flag.
module pipelined_mux_n #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_IN*WIDTH-1:0] IN_DATA,
    input  logic [SEL_W-1:0]        SELECT,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [WIDTH-1:0]        OUT_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    SEL_ERR,
    input  logic                    ERR_CLR,
    output logic [CNT_W-1:0]        XFER_CNT
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] sel_word;
    logic             sel_oob;
    logic             in_acc;
    logic             out_acc;

    // Pick the addressed input; unused codes yield zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (32'(SELECT) == 32'(k)) begin
                sel_word = IN_DATA[k*WIDTH +: WIDTH];
            end
        end
    end

    // Handshake qualifiers and out-of-range select detect.
    always_comb begin
        sel_oob = 32'(SELECT) >= 32'(NUM_IN);
        in_acc  = IN_VALID & IN_READY;
        out_acc = OUT_VALID & OUT_READY;
    end

    // Occupancy FSM driving the main and skid registers.
    // IN_READY is kept as its own flop so it never sees OUT_READY.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= EMPTY;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            skid_data <= '0;
            IN_READY  <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_acc) begin
                        OUT_DATA  <= sel_word;
                        OUT_VALID <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_acc && out_acc) begin
                        OUT_DATA <= sel_word;
                    end else if (in_acc) begin
                        skid_data <= sel_word;
                        IN_READY  <= 1'b0;
                        state     <= FULL;
                    end else if (out_acc) begin
                        OUT_VALID <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_acc) begin
                        OUT_DATA <= skid_data;
                        IN_READY <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    OUT_VALID <= 1'b0;
                    IN_READY  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end

    // Sticky select error; a new error beats a same-cycle clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SEL_ERR <= 1'b0;
        end else if (in_acc && sel_oob) begin
            SEL_ERR <= 1'b1;
        end else if (ERR_CLR) begin
            SEL_ERR <= 1'b0;
        end
    end

    // Count words delivered downstream, wrapping freely.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            XFER_CNT <= '0;
        end else if (out_acc) begin
            XFER_CNT <= XFER_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipelined_mux_n.sv
// Bench for pipelined_mux_n: directed table, corner sequences,
// and a randomised valid/ready run against a queue model.
module tb_pipelined_mux_n;

    logic        clk;
    logic        rst;

    // Instance A: default parameters
    logic [31:0] a_in;
    logic [1:0]  a_sel;
    logic        a_iv, a_ir, a_ov, a_or, a_err, a_clr;
    logic [7:0]  a_od, a_cnt;

    // Instance B: NUM_IN=3, CNT_W=4
    logic [23:0] b_in;
    logic [1:0]  b_sel;
    logic        b_iv, b_ir, b_ov, b_or, b_err, b_clr;
    logic [7:0]  b_od;
    logic [3:0]  b_cnt;

    int tests = 0;
    int fails = 0;

    pipelined_mux_n #(.WIDTH(8), .NUM_IN(4), .SEL_W(2), .CNT_W(8)) dut_a (
        .CLK(clk), .RESET(rst), .IN_DATA(a_in), .SELECT(a_sel),
        .IN_VALID(a_iv), .IN_READY(a_ir), .OUT_DATA(a_od),
        .OUT_VALID(a_ov), .OUT_READY(a_or), .SEL_ERR(a_err),
        .ERR_CLR(a_clr), .XFER_CNT(a_cnt)
    );

    pipelined_mux_n #(.WIDTH(8), .NUM_IN(3), .SEL_W(2), .CNT_W(4)) dut_b (
        .CLK(clk), .RESET(rst), .IN_DATA(b_in), .SELECT(b_sel),
        .IN_VALID(b_iv), .IN_READY(b_ir), .OUT_DATA(b_od),
        .OUT_VALID(b_ov), .OUT_READY(b_or), .SEL_ERR(b_err),
        .ERR_CLR(b_clr), .XFER_CNT(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic       iv;
        logic       ordy;
        logic [7:0] d;
        logic       v;
        logic       ir;
        logic [7:0] c;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [7:0] q[$];
    logic [7:0] words [4];
    logic [7:0] mcnt;
    logic [7:0] exp_w;
    bit         m_in, m_out;

    initial begin
        rst   = 1'b1;
        a_in  = 32'h44332211;
        a_sel = '0; a_iv = 0; a_or = 0; a_clr = 0;
        b_in  = 24'h332211;
        b_sel = '0; b_iv = 0; b_or = 0; b_clr = 0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_data", 32'(a_od), 32'h0);
        chk("rst_valid", 32'(a_ov), 32'h0);
        chk("rst_ready", 32'(a_ir), 32'h1);
        chk("rst_err", 32'(a_err), 32'h0);
        chk("rst_cnt", 32'(a_cnt), 32'h0);

        // Single word, then back-pressure into FULL and drain
        tbl[0] = '{2'd2, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'd0};
        tbl[1] = '{2'd0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'd1};
        tbl[2] = '{2'd0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 8'd1};
        tbl[3] = '{2'd3, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'd1};
        tbl[4] = '{2'd1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'd1};
        tbl[5] = '{2'd0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 8'd2};
        tbl[6] = '{2'd0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 8'd3};
        for (int i = 0; i < 7; i++) begin
            a_sel = tbl[i].sel;
            a_iv  = tbl[i].iv;
            a_or  = tbl[i].ordy;
            step();
            chk($sformatf("tbl%0d_data", i), 32'(a_od), 32'(tbl[i].d));
            chk($sformatf("tbl%0d_valid", i), 32'(a_ov), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_ready", i), 32'(a_ir), 32'(tbl[i].ir));
            chk($sformatf("tbl%0d_cnt", i), 32'(a_cnt), 32'(tbl[i].c));
        end

        // Streaming: 16 words back to back
        do_reset();
        words[0] = 8'h11; words[1] = 8'h22;
        words[2] = 8'h33; words[3] = 8'h44;
        a_or = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_sel = 2'(i % 4);
            a_iv  = 1'b1;
            step();
            chk($sformatf("strm%0d_data", i), 32'(a_od), 32'(words[i % 4]));
            chk($sformatf("strm%0d_valid", i), 32'(a_ov), 32'h1);
        end
        a_iv = 1'b0;
        step();
        chk("strm_end_valid", 32'(a_ov), 32'h0);
        chk("strm_end_cnt", 32'(a_cnt), 32'd16);

        // Select errors on the 3-input instance
        b_or  = 1'b1;
        b_sel = 2'd1; b_iv = 1'b1;
        step();
        chk("b_sel1_data", 32'(b_od), 32'h22);
        chk("b_sel1_err", 32'(b_err), 32'h0);
        b_sel = 2'd3;
        step();
        chk("b_oob_data", 32'(b_od), 32'h0);
        chk("b_oob_valid", 32'(b_ov), 32'h1);
        chk("b_oob_err", 32'(b_err), 32'h1);
        b_iv = 1'b0;
        step();
        chk("b_sticky", 32'(b_err), 32'h1);
        b_clr = 1'b1;
        step();
        chk("b_clr", 32'(b_err), 32'h0);
        b_iv = 1'b1; b_sel = 2'd3;
        step();
        chk("b_set_wins", 32'(b_err), 32'h1);
        b_iv = 1'b0; b_clr = 1'b0;
        step();
        chk("b_cnt_oob", 32'(b_cnt), 32'd3);

        // Counter wrap with CNT_W=4
        do_reset();
        b_or = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            b_sel = 2'(j % 3);
            b_iv  = (j <= 17);
            step();
            chk($sformatf("wrap%0d_cnt", j), 32'(b_cnt), 32'((j - 1) % 16));
        end
        b_iv = 1'b0;

        // Asynchronous reset while FULL
        a_or = 1'b0; a_iv = 1'b1; a_sel = 2'd1;
        step();
        a_sel = 2'd2;
        step();
        a_iv = 1'b0;
        chk("pre_rst_ready", 32'(a_ir), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(a_ov), 32'h0);
        chk("async_ready", 32'(a_ir), 32'h1);
        chk("async_cnt", 32'(a_cnt), 32'h0);
        step();
        #2;
        rst = 1'b0;
        a_or = 1'b1;
        step();
        chk("post_rst_valid0", 32'(a_ov), 32'h0);
        step();
        chk("post_rst_valid1", 32'(a_ov), 32'h0);
        chk("post_rst_cnt", 32'(a_cnt), 32'h0);

        // Random valid/ready against a queue model
        do_reset();
        q.delete();
        mcnt = '0;
        for (int n = 0; n < 10000; n++) begin
            chk("rnd_valid", 32'(a_ov), 32'(q.size() > 0));
            chk("rnd_ready", 32'(a_ir), 32'(q.size() < 2));
            if (q.size() > 0) chk("rnd_data", 32'(a_od), 32'(q[0]));
            if (n % 64 == 63) chk("rnd_cnt", 32'(a_cnt), 32'(mcnt));
            a_in  = $urandom;
            a_sel = 2'($urandom_range(0, 3));
            a_iv  = 1'($urandom_range(0, 1));
            a_or  = 1'($urandom_range(0, 1));
            exp_w = a_in[a_sel*8 +: 8];
            m_out = (q.size() > 0) && a_or;
            m_in  = a_iv && (q.size() < 2);
            if (m_out) begin
                void'(q.pop_front());
                mcnt++;
            end
            if (m_in) q.push_back(exp_w);
            step();
        end
        chk("rnd_final_cnt", 32'(a_cnt), 32'(mcnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_mux_n.md
Name: pipelined_mux_n

Overview:
Parametrised, registered N-way word multiplexer with valid/ready flow control, for ALU result selection and operand selection in the datapath. It generalises the fixed 8-bit 2:1 and 1-bit 3:1 selectors to WIDTH bits and NUM_IN inputs. It adds a one-stage pipeline register with a skid buffer, sticky out-of-range-select detection, and an accepted-transfer counter.

Parameters:
WIDTH, 8, data word width in bits (1..32)
NUM_IN, 4, number of data inputs (2..8); requires NUM_IN <= 2**SEL_W
SEL_W, 2, select field width in bits (1..3)
CNT_W, 8, width of the transfer counter

Ports:
CLK  input  1  clock, rising-edge
RESET  input  1  asynchronous, active-high reset
IN_DATA  input  NUM_IN*WIDTH  packed inputs; input k is at bits [k*WIDTH +: WIDTH]
SELECT  input  SEL_W  binary index of the input to forward; sampled with IN_DATA
IN_VALID  input  1  upstream word and select are valid
IN_READY  output  1  block can accept a word this cycle
OUT_DATA  output  WIDTH  selected word (registered)
OUT_VALID  output  1  OUT_DATA holds a valid word
OUT_READY  input  1  downstream accepts OUT_DATA this cycle
SEL_ERR  output  1  sticky flag: an out-of-range SELECT was accepted
ERR_CLR  input  1  synchronous clear of SEL_ERR
XFER_CNT  output  CNT_W  count of words delivered downstream, wrapping

Behaviour:
- Reset (asynchronous, active-high): OUT_DATA=0, OUT_VALID=0, skid buffer empty, IN_READY=1, SEL_ERR=0, XFER_CNT=0. Reset asserted mid-transfer discards all buffered words immediately.
- Selection: sel_word = input[SELECT] when SELECT < NUM_IN; otherwise sel_word = all zeros. This matches the existing 3:1 selector returning 0 on an unused code.
- Handshake: input accept = IN_VALID & IN_READY; output accept = OUT_VALID & OUT_READY. Data and select are sampled only on input accept.
- IN_READY = skid buffer empty. It is a direct register output, with no combinational path from OUT_READY.
- Storage: main register (OUT_DATA/OUT_VALID) plus one skid register. States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (main and skid valid).
- Transitions:
  - EMPTY + accept -> ONE; main loads sel_word. Latency is 1 cycle from accept to OUT_VALID.
  - ONE + accept + output accept -> ONE; main reloads.
  - ONE + accept, no output accept -> FULL; skid loads sel_word.
  - ONE + output accept only -> EMPTY.
  - FULL + output accept -> ONE; main loads skid, skid clears. No input accept is possible in FULL since IN_READY=0.
  - FULL, no output accept -> hold.
- OUT_DATA and OUT_VALID are stable while OUT_VALID=1 and OUT_READY=0. Ordering is strictly FIFO, and no word is lost or duplicated.
- Sustained throughput is 1 word/cycle when OUT_READY stays high.
- SEL_ERR: set the cycle after an input accept with SELECT >= NUM_IN. It stays set until ERR_CLR.
  - ERR_CLR and a new error in the same cycle: set wins, and SEL_ERR stays 1.
  - Out-of-range words still propagate as zeros and count as transfers.
- XFER_CNT: increments by 1 on each output accept. It wraps from 2**CNT_W-1 to 0, with no saturation.
- OUT_DATA is not cleared when OUT_VALID falls; it holds its last value.

Test Plan:
1. Reset, then WIDTH=8, NUM_IN=4, inputs {0x11,0x22,0x33,0x44}, SELECT=2, IN_VALID=1 for one cycle, OUT_READY=1 -> next cycle OUT_DATA=0x33, OUT_VALID=1; the following cycle OUT_VALID=0 and XFER_CNT=1.
2. Back-pressure: OUT_READY=0; send SELECT=0 then SELECT=3 -> OUT_DATA=0x11 held; IN_READY=0 after the second accept. Raise OUT_READY -> 0x11 then 0x44 on consecutive cycles, then IN_READY=1.
3. Streaming: 16 back-to-back words with SELECT cycling 0..3 and OUT_READY=1 -> 16 outputs on 16 consecutive cycles, in order, with XFER_CNT=16.
4. NUM_IN=3, SEL_W=2, SELECT=3 accepted -> OUT_DATA=0x00 and SEL_ERR=1. ERR_CLR=1 alone -> SEL_ERR=0. ERR_CLR together with another SELECT=3 accept -> SEL_ERR stays 1.
5. Reset mid-operation: FULL state, assert RESET asynchronously between clock edges -> OUT_VALID=0, IN_READY=1, XFER_CNT=0 immediately. No stale word appears after release.
6. CNT_W=4: 17 delivered words -> XFER_CNT sequence reaches 15, wraps to 0, ends at 1. Also run random valid/ready toggling for 10k cycles against a scoreboard -> zero mismatches.
